// File: rtl/gate2_sweep_checker.sv
// ---------------------------------------------------------------------------
// gate2_sweep_checker
//
// Clocked stimulus-and-check engine for a 2-input combinational gate. A run
// drives {in1,in2} through 00,01,10,11, holds each vector for SETTLE cycles,
// samples dut_out for one more cycle and compares it with TRUTH[{in1,in2}].
// The whole 4-vector sweep is repeated PASSES times. Mismatches are counted
// (saturating at 255) and the failing vector indices are recorded.
//
// Parameters
//   TRUTH   expected gate output indexed by {in1,in2} (default NOR)
//   SETTLE  cycles each vector is held before its sample cycle (1..255)
//   PASSES  number of full sweeps per run (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      begins a run when sampled high in IDLE or DONE
//   dut_out    output of the gate under test (sampled only in SAMPLE)
//   in1, in2   registered stimulus to the gate under test
//   busy       high while a run is in progress
//   done       high once a run completes, until the next accepted start
//   pass       valid while done=1; high iff no mismatch was seen
//   err_count  saturating mismatch count of the current run
//   fail_vec   bit i set if vector i mismatched in any pass
// ---------------------------------------------------------------------------
module gate2_sweep_checker #(
    parameter logic [3:0]  TRUTH  = 4'b0001,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Terminal counts of the settle and pass counters.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    state_t     state_q,      state_d;
    logic [1:0] idx_q,        idx_d;
    logic [7:0] settle_cnt_q, settle_cnt_d;
    logic [7:0] pass_cnt_q,   pass_cnt_d;
    logic [1:0] vec_q,        vec_d;        // {in1,in2}
    logic       busy_q,       busy_d;
    logic       done_q,       done_d;
    logic       pass_q,       pass_d;
    logic [7:0] err_q,        err_d;
    logic [3:0] fail_vec_q,   fail_vec_d;

    // Helper values for the SAMPLE cycle.
    logic       mismatch;
    logic [7:0] err_upd;
    logic [1:0] idx_inc;
    logic       last_sample;

    always_comb begin
        mismatch    = (dut_out != TRUTH[idx_q]);
        // Saturate at 255 rather than wrapping back to a passing-looking zero.
        err_upd     = (mismatch && (err_q != 8'hFF)) ? (err_q + 8'd1) : err_q;
        // 2-bit increment wraps 3 -> 0 naturally at the end of a sweep.
        idx_inc     = idx_q + 2'd1;
        last_sample = (idx_q == 2'd3) && (pass_cnt_q == PASS_LAST);
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        vec_d        = vec_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_vec_d   = fail_vec_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_d        = 8'd0;
                    fail_vec_d   = 4'd0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    idx_d        = 2'd0;
                    pass_cnt_d   = 8'd0;
                    settle_cnt_d = 8'd0;
                    vec_d        = 2'b00;
                    busy_d       = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    settle_cnt_d = 8'd0;
                    state_d      = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end

            ST_SAMPLE: begin
                err_d = err_upd;
                if (mismatch) begin
                    fail_vec_d = fail_vec_q | (4'b0001 << idx_q);
                end
                if (last_sample) begin
                    // Verdict includes the sample taken in this very cycle.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_upd == 8'd0);
                    state_d = ST_DONE;
                end else begin
                    if (idx_q == 2'd3) begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                    end
                    idx_d   = idx_inc;
                    vec_d   = idx_inc;
                    state_d = ST_SETTLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            settle_cnt_q <= 8'd0;
            pass_cnt_q   <= 8'd0;
            vec_q        <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= 8'd0;
            fail_vec_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    // All outputs come straight from flops.
    assign in1       = vec_q[1];
    assign in2       = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_gate2_sweep_checker.sv
// ---------------------------------------------------------------------------
// Bench for gate2_sweep_checker. Three instances with different SETTLE/PASSES
// share one clock and reset; each drives its own gate model (a 4-entry truth
// table selectable at run time). Table-driven runs, random gate runs checked
// against an arithmetic model, plus hand-written busy-start / reset / restart
// sequences.
// ---------------------------------------------------------------------------
module tb_gate2_sweep_checker;

    localparam logic [3:0] NOR_TT = 4'b0001;
    localparam logic [3:0] AND_TT = 4'b1000;

    localparam int S_P [3] = '{2, 1, 1};
    localparam int P_P [3] = '{1, 3, 100};

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a   [3];
    logic [3:0] tt        [3];
    logic       dut_out_a [3];
    logic       in1_a     [3];
    logic       in2_a     [3];
    logic       busy_a    [3];
    logic       done_a    [3];
    logic       pass_a    [3];
    logic [7:0] err_a     [3];
    logic [3:0] fv_a      [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Gate models: output looked up from the selected truth table.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_gate
            assign dut_out_a[gi] = tt[gi][{in1_a[gi], in2_a[gi]}];
        end
    endgenerate

    gate2_sweep_checker #(.TRUTH(NOR_TT), .SETTLE(2), .PASSES(1)) u_def (
        .clk(clk), .rst(rst), .start(start_a[0]), .dut_out(dut_out_a[0]),
        .in1(in1_a[0]), .in2(in2_a[0]), .busy(busy_a[0]), .done(done_a[0]),
        .pass(pass_a[0]), .err_count(err_a[0]), .fail_vec(fv_a[0]));

    gate2_sweep_checker #(.TRUTH(NOR_TT), .SETTLE(1), .PASSES(3)) u_fast (
        .clk(clk), .rst(rst), .start(start_a[1]), .dut_out(dut_out_a[1]),
        .in1(in1_a[1]), .in2(in2_a[1]), .busy(busy_a[1]), .done(done_a[1]),
        .pass(pass_a[1]), .err_count(err_a[1]), .fail_vec(fv_a[1]));

    gate2_sweep_checker #(.TRUTH(NOR_TT), .SETTLE(1), .PASSES(100)) u_sat (
        .clk(clk), .rst(rst), .start(start_a[2]), .dut_out(dut_out_a[2]),
        .in1(in1_a[2]), .in2(in2_a[2]), .busy(busy_a[2]), .done(done_a[2]),
        .pass(pass_a[2]), .err_count(err_a[2]), .fail_vec(fv_a[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: every mismatching vector fails once per pass.
    function automatic logic [7:0] model_err(input int sel, input logic [3:0] gate);
        int total;
        total = P_P[sel] * $countones(gate ^ NOR_TT);
        return (total > 255) ? 8'd255 : 8'(total);
    endfunction

    // One complete run: vector sequence checked every cycle, verdict at the end.
    task automatic run_check(input int sel, input logic [3:0] gate, input logic [7:0] e_err,
                             input logic [3:0] e_fv, input logic e_pass, input string tag);
        int s;
        int n;
        s = S_P[sel];
        n = 4 * P_P[sel] * (s + 1);
        tt[sel] = gate;
        @(negedge clk);
        start_a[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_a[sel] = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk({tag, "_vec"}, {30'd0, in1_a[sel], in2_a[sel]}, 32'((k / (s + 1)) % 4));
            chk({tag, "_busy"}, {31'd0, busy_a[sel]}, 32'd1);
            chk({tag, "_done_low"}, {31'd0, done_a[sel]}, 32'd0);
            if (k == 0) begin
                chk({tag, "_err_clr"}, {24'd0, err_a[sel]}, 32'd0);
                chk({tag, "_fv_clr"}, {28'd0, fv_a[sel]}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_done"}, {31'd0, done_a[sel]}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy_a[sel]}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass_a[sel]}, {31'd0, e_pass});
        chk({tag, "_err"}, {24'd0, err_a[sel]}, {24'd0, e_err});
        chk({tag, "_fv"}, {28'd0, fv_a[sel]}, {28'd0, e_fv});
        chk({tag, "_lastvec"}, {30'd0, in1_a[sel], in2_a[sel]}, 32'd3);
        $display("run %s sel=%0d gate=%b err=%0d fv=%b pass=%0b", tag, sel, gate,
                 err_a[sel], fv_a[sel], pass_a[sel]);
    endtask

    typedef struct {
        int         sel;
        logic [3:0] gate;
        logic [7:0] e_err;
        logic [3:0] e_fv;
        logic       e_pass;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{0, 4'b0001, 8'd0,   4'b0000, 1'b1};   // correct NOR
        tbl[1] = '{0, 4'b1000, 8'd2,   4'b1001, 1'b0};   // AND as DUT
        tbl[2] = '{1, 4'b0000, 8'd3,   4'b0001, 1'b0};   // stuck-at-0, 3 passes
        tbl[3] = '{2, 4'b1111, 8'd255, 4'b1110, 1'b0};   // stuck-at-1, saturates
        tbl[4] = '{0, 4'b0110, 8'd3,   4'b0111, 1'b0};   // XOR
        tbl[5] = '{1, 4'b1110, 8'd12,  4'b1111, 1'b0};   // OR, 3 passes

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            tt[i]      = NOR_TT;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", {31'd0, busy_a[i]}, 32'd0);
            chk("rst_done", {31'd0, done_a[i]}, 32'd0);
            chk("rst_pass", {31'd0, pass_a[i]}, 32'd0);
            chk("rst_vec", {30'd0, in1_a[i], in2_a[i]}, 32'd0);
            chk("rst_err", {24'd0, err_a[i]}, 32'd0);
            chk("rst_fv", {28'd0, fv_a[i]}, 32'd0);
        end
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            run_check(tbl[t].sel, tbl[t].gate, tbl[t].e_err, tbl[t].e_fv, tbl[t].e_pass,
                      $sformatf("tbl%0d", t));
        end

        // Restart from DONE: previous table run left instance 0 failing? Make sure.
        run_check(0, AND_TT, 8'd2, 4'b1001, 1'b0, "and_before_restart");
        run_check(0, NOR_TT, 8'd0, 4'b0000, 1'b1, "restart_nor");

        // Starts while busy are ignored, then async reset mid-run.
        tt[0] = AND_TT;
        @(negedge clk);
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            start_a[0] = (k == 1 || k == 6);
            chk("busy_start_vec", {30'd0, in1_a[0], in2_a[0]}, 32'((k / 3) % 4));
            if (k == 7) begin
                chk("busy_start_err", {24'd0, err_a[0]}, 32'd1);
                chk("busy_start_fv", {28'd0, fv_a[0]}, 32'd1);
            end
        end
        start_a[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_vec", {30'd0, in1_a[0], in2_a[0]}, 32'd0);
        chk("async_rst_busy", {31'd0, busy_a[0]}, 32'd0);
        chk("async_rst_err", {24'd0, err_a[0]}, 32'd0);
        chk("async_rst_fv", {28'd0, fv_a[0]}, 32'd0);
        $display("async reset mid-run applied");
        @(negedge clk);
        rst = 1'b0;
        run_check(0, NOR_TT, 8'd0, 4'b0000, 1'b1, "after_rst");

        // Random gates checked against the arithmetic model.
        for (int r = 0; r < 12; r++) begin
            int         sel;
            logic [3:0] gate;
            sel  = int'($urandom_range(0, 1));
            gate = 4'($urandom);
            run_check(sel, gate, model_err(sel, gate), gate ^ NOR_TT,
                      model_err(sel, gate) == 8'd0, $sformatf("rnd%0d", r));
        end
        run_check(2, 4'b0111, model_err(2, 4'b0111), 4'b0111 ^ NOR_TT, 1'b0, "rnd_sat");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
